pipe_stage_reg: RTL and testbench

Parametrised pipeline boundary register that replaces the fixed-width EX/MEM register with a generic, flow-controlled stage. It carries an opaque data payload plus a control field across one stage boundary and adds valid/ready handshaking, optional skid buffering, flush, and asynchronous reset. It is instantiated between every pair of pipeline stages: IF/ID, ID/EX, EX/MEM and MEM/WB. Latency is exactly one cycle; there is no extra internal staging.

---
 rtl/pipe_pkg.sv | 59 +++++
 rtl/pipe_stage_reg_if.sv | 35 +++
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline field map: bit offsets and widths of the payload carried
// across each stage boundary, plus packing helpers for the EX/MEM beat.
package pipe_pkg;

    // Control class widths (write-back and memory control groups)
    localparam int WB_W        = 2;
    localparam int M_W         = 3;
    localparam int PIPE_CTRL_W = WB_W + M_W;

    // EX/MEM payload layout
    localparam int ALU_LSB   = 0;
    localparam int ZERO_BIT  = 64;
    localparam int ADDER_LSB = 65;
    localparam int WB_LSB    = 129;
    localparam int M_LSB     = 131;
    localparam int RD2_LSB   = 134;
    localparam int RD_LSB    = 198;
    localparam int EXMEM_W   = 203;

    // IF/ID payload layout: pc, instruction
    localparam int IFID_PC_LSB    = 0;
    localparam int IFID_INSTR_LSB = 64;
    localparam int IFID_W         = 96;

    // ID/EX payload layout: pc, rs1 data, rs2 data, immediate, funct, rd
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_RD1_LSB   = 64;
    localparam int IDEX_RD2_LSB   = 128;
    localparam int IDEX_IMM_LSB   = 192;
    localparam int IDEX_FUNCT_LSB = 256;
    localparam int IDEX_RD_LSB    = 260;
    localparam int IDEX_W         = 265;

    // MEM/WB payload layout: load data, alu result, rd
    localparam int MEMWB_RDATA_LSB = 0;
    localparam int MEMWB_ALU_LSB   = 64;
    localparam int MEMWB_RD_LSB    = 128;
    localparam int MEMWB_W         = 133;

    // Control field as carried on ICtrl/OCtrl: memory group above write-back
    typedef struct packed {
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } stage_ctrl_t;

    // Assemble an EX/MEM payload from its named fields
    function automatic logic [EXMEM_W-1:0] exmem_pack(
        input logic [63:0]     alu,
        input logic            zero,
        input logic [63:0]     adder,
        input logic [WB_W-1:0] wb,
        input logic [M_W-1:0]  m,
        input logic [63:0]     rd2,
        input logic [4:0]      rd
    );
        return {rd, rd2, m, wb, adder, zero, alu};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Flow-controlled stage boundary bundle: upstream beat in, downstream beat out.
//
// Handshake: a beat moves across a port on a rising edge exactly when both
// its valid and its ready are 1 on that edge. A producer holding valid=1
// keeps its data stable until the beat moves; ready may depend on the
// partner's valid but valid never depends on ready.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CTRL_W = PIPE_CTRL_W
);
    logic              IValid;
    logic              IReady;
    logic [DATA_W-1:0] IData;
    logic [CTRL_W-1:0] ICtrl;
    logic              Flush;
    logic              OValid;
    logic              OReady;
    logic [DATA_W-1:0] OData;
    logic [CTRL_W-1:0] OCtrl;
    logic [1:0]        Count;

    // Environment side: drives the upstream beat, flush and downstream ready
    modport master (
        output IValid, IData, ICtrl, Flush, OReady,
        input  IReady, OValid, OData, OCtrl, Count
    );

    // Stage side
    modport slave (
        input  IValid, IData, ICtrl, Flush, OReady,
        output IReady, OValid, OData, OCtrl, Count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid/ready flow control,
// optional skid entry, synchronous flush and asynchronous active-low reset.
// Main entry M drives the outputs; skid entry S exists only when SKID=1.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = EXMEM_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter bit SKID   = 1'b1
)(
    input  logic             Clk,
    input  logic             Rst_n,
    pipe_stage_reg_if.slave  bus
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = bus.IValid & in_ready;
    assign out_fire = m_valid & bus.OReady;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] s_data;
            logic [CTRL_W-1:0] s_ctrl;

            // Ready only depends on the skid register, so it never sees OReady
            assign in_ready = ~s_valid;

            // Two-entry FIFO: M refills from S first, S catches the beat that
            // arrives while M is stalled
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= '0;
                    s_valid <= 1'b0;
                    s_data  <= '0;
                    s_ctrl  <= '0;
                end else if (bus.Flush) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                end else if (out_fire) begin
                    if (s_valid) begin
                        m_data  <= s_data;
                        m_ctrl  <= s_ctrl;
                        s_valid <= 1'b0;
                    end else if (in_fire) begin
                        m_data  <= bus.IData;
                        m_ctrl  <= bus.ICtrl;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end else if (in_fire) begin
                    if (m_valid) begin
                        s_valid <= 1'b1;
                        s_data  <= bus.IData;
                        s_ctrl  <= bus.ICtrl;
                    end else begin
                        m_valid <= 1'b1;
                        m_data  <= bus.IData;
                        m_ctrl  <= bus.ICtrl;
                    end
                end
            end
        end else begin : g_single
            assign s_valid  = 1'b0;
            // Accept when empty or when the held beat leaves this same edge
            assign in_ready = ~m_valid | bus.OReady;

            // Single entry: load on every accepted beat, empty on drain
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                    m_ctrl  <= '0;
                end else if (bus.Flush) begin
                    m_valid <= 1'b0;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_data  <= bus.IData;
                    m_ctrl  <= bus.ICtrl;
                end else if (out_fire) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.IReady = in_ready;
    assign bus.OValid = m_valid;
    assign bus.OData  = m_data;
    // Bubbles carry no control so they never write the register file or memory
    assign bus.OCtrl  = m_valid ? m_ctrl : '0;
    assign bus.Count  = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance see the same
// stimulus; each is compared with a queue model of the stage contents.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int CW = 5;
    localparam int BW = DW + CW;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          rst_n = 1'b0;
    logic          iv    = 1'b0;
    logic [DW-1:0] id    = '0;
    logic [CW-1:0] ic    = '0;
    logic          fl    = 1'b0;
    logic          ordy  = 1'b0;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();

    assign bus1.IValid = iv;
    assign bus1.IData  = id;
    assign bus1.ICtrl  = ic;
    assign bus1.Flush  = fl;
    assign bus1.OReady = ordy;
    assign bus0.IValid = iv;
    assign bus0.IData  = id;
    assign bus0.ICtrl  = ic;
    assign bus0.Flush  = fl;
    assign bus0.OReady = ordy;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
        .Clk   (Clk),
        .Rst_n (rst_n),
        .bus   (bus1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
        .Clk   (Clk),
        .Rst_n (rst_n),
        .bus   (bus0)
    );

    // ---------------- scoreboard ----------------
    // Each entry is {ctrl, data}; front of the queue is the beat on the outputs
    logic [BW-1:0] exp_q1[$];
    logic [BW-1:0] exp_q0[$];
    int n_cmp = 0;
    int n_err = 0;

    // Apply the stage rules for the coming edge: flush/reset empty the stage,
    // otherwise the front beat leaves when downstream is ready and a new beat
    // joins the back when there is room (capacity 2 with skid, 1 without,
    // where the single entry may be replaced in the same cycle it drains).
    task automatic model_edge();
        logic [BW-1:0] b;
        bit in1, out1, in0, out0;
        b = {ic, id};
        if (!rst_n || fl) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            out1 = (exp_q1.size() != 0) && ordy;
            in1  = iv && (exp_q1.size() < 2);
            out0 = (exp_q0.size() != 0) && ordy;
            in0  = iv && ((exp_q0.size() == 0) || ordy);
            if (out1) void'(exp_q1.pop_front());
            if (in1)  exp_q1.push_back(b);
            if (out0) void'(exp_q0.pop_front());
            if (in0)  exp_q0.push_back(b);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic f, input logic r);
        iv   = v;
        id   = d;
        ic   = c;
        fl   = f;
        ordy = r;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'h5A, 5'd3, 1'b0, 1'b1);
        tick();
        tick();
        n_cmp++; if (bus1.OValid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid1: got %0b want 0", bus1.OValid); end
        n_cmp++; if (bus1.OData !== 32'h0) begin n_err++; $display("FAIL reset_odata1: got %0h want 0", bus1.OData); end
        n_cmp++; if (bus1.OCtrl !== 5'h0) begin n_err++; $display("FAIL reset_octrl1: got %0h want 0", bus1.OCtrl); end
        n_cmp++; if (bus1.Count !== 2'd0) begin n_err++; $display("FAIL reset_count1: got %0d want 0", bus1.Count); end
        n_cmp++; if (bus1.IReady !== 1'b1) begin n_err++; $display("FAIL reset_iready1: got %0b want 1", bus1.IReady); end
        n_cmp++; if (bus0.IReady !== 1'b1) begin n_err++; $display("FAIL reset_iready0: got %0b want 1", bus0.IReady); end
        n_cmp++; if (bus0.OValid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid0: got %0b want 0", bus0.OValid); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus1.OValid !== 1'b1 || bus1.OData !== 32'h5A) begin n_err++; $display("FAIL reset_first1: got v=%0b d=%0h want v=1 d=5a", bus1.OValid, bus1.OData); end
        n_cmp++; if (bus1.OCtrl !== 5'd3) begin n_err++; $display("FAIL reset_first_ctrl1: got %0h want 3", bus1.OCtrl); end
        n_cmp++; if (bus0.OValid !== 1'b1 || bus0.OData !== 32'h5A) begin n_err++; $display("FAIL reset_first0: got v=%0b d=%0h want v=1 d=5a", bus0.OValid, bus0.OData); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (bus1.Count !== 2'd0 || bus0.Count !== 2'd0) begin n_err++; $display("FAIL reset_drain: got %0d/%0d want 0/0", bus1.Count, bus0.Count); end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 5'd1, 1'b0, 1'b1);
            tick();
            n_cmp++; if (bus1.OValid !== 1'b1 || bus1.OData !== DW'(i)) begin n_err++; $display("FAIL stream1_%0d: got v=%0b d=%0h want v=1 d=%0h", i, bus1.OValid, bus1.OData, i); end
            n_cmp++; if (bus1.Count !== 2'd1) begin n_err++; $display("FAIL stream1_count_%0d: got %0d want 1", i, bus1.Count); end
            n_cmp++; if (bus0.OValid !== 1'b1 || bus0.OData !== DW'(i)) begin n_err++; $display("FAIL stream0_%0d: got v=%0b d=%0h want v=1 d=%0h", i, bus0.OValid, bus0.OData, i); end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (bus1.OValid !== 1'b0 || bus1.OCtrl !== 5'd0) begin n_err++; $display("FAIL stream_end: got v=%0b c=%0h want v=0 c=0", bus1.OValid, bus1.OCtrl); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'hA, 5'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 5'd4, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus1.OData !== 32'hA) begin n_err++; $display("FAIL bp_hold1: got %0h want a", bus1.OData); end
        n_cmp++; if (bus1.Count !== 2'd2) begin n_err++; $display("FAIL bp_count1: got %0d want 2", bus1.Count); end
        n_cmp++; if (bus1.IReady !== 1'b0) begin n_err++; $display("FAIL bp_iready1: got %0b want 0", bus1.IReady); end
        n_cmp++; if (bus0.OData !== 32'hA || bus0.Count !== 2'd1) begin n_err++; $display("FAIL bp_hold0: got d=%0h n=%0d want d=a n=1", bus0.OData, bus0.Count); end
        n_cmp++; if (bus0.IReady !== 1'b0) begin n_err++; $display("FAIL bp_iready0: got %0b want 0", bus0.IReady); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        #1;
        n_cmp++; if (bus0.IReady !== 1'b1) begin n_err++; $display("FAIL bp_iready0_comb: got %0b want 1", bus0.IReady); end
        n_cmp++; if (bus1.IReady !== 1'b0) begin n_err++; $display("FAIL bp_iready1_reg: got %0b want 0", bus1.IReady); end
        tick();
        n_cmp++; if (bus1.OValid !== 1'b1 || bus1.OData !== 32'hB || bus1.OCtrl !== 5'd4) begin n_err++; $display("FAIL bp_second1: got v=%0b d=%0h c=%0h want v=1 d=b c=4", bus1.OValid, bus1.OData, bus1.OCtrl); end
        n_cmp++; if (bus0.Count !== 2'd0) begin n_err++; $display("FAIL bp_drain0: got %0d want 0", bus0.Count); end
        tick();
        n_cmp++; if (bus1.Count !== 2'd0) begin n_err++; $display("FAIL bp_drain1: got %0d want 0", bus1.Count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h1, 5'b10110, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h2, 5'b10110, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus1.Count !== 2'd2 || bus1.OCtrl !== 5'b10110) begin n_err++; $display("FAIL flush_pre: got n=%0d c=%0h want n=2 c=16", bus1.Count, bus1.OCtrl); end
        drive(1'b1, 32'h3, 5'b10110, 1'b1, 1'b0);
        tick();
        n_cmp++; if (bus1.OValid !== 1'b0 || bus1.OCtrl !== 5'd0) begin n_err++; $display("FAIL flush_out1: got v=%0b c=%0h want v=0 c=0", bus1.OValid, bus1.OCtrl); end
        n_cmp++; if (bus1.Count !== 2'd0 || bus0.Count !== 2'd0) begin n_err++; $display("FAIL flush_count: got %0d/%0d want 0/0", bus1.Count, bus0.Count); end
        n_cmp++; if (bus0.OCtrl !== 5'd0) begin n_err++; $display("FAIL flush_octrl0: got %0h want 0", bus0.OCtrl); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        n_cmp++; if (bus1.OValid !== 1'b0 || bus0.OValid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got %0b/%0b want 0/0", bus1.OValid, bus0.OValid); end
    endtask

    task automatic test_skid0_stall();
        drive(1'b1, 32'h11, 5'd7, 1'b0, 1'b0);
        tick();
        n_cmp++; if (bus0.OValid !== 1'b1 || bus0.IReady !== 1'b0) begin n_err++; $display("FAIL s0_stall: got v=%0b r=%0b want v=1 r=0", bus0.OValid, bus0.IReady); end
        drive(1'b1, 32'h22, 5'd9, 1'b0, 1'b1);
        #1;
        n_cmp++; if (bus0.IReady !== 1'b1) begin n_err++; $display("FAIL s0_ready_comb: got %0b want 1", bus0.IReady); end
        tick();
        n_cmp++; if (bus0.OValid !== 1'b1 || bus0.OData !== 32'h22 || bus0.OCtrl !== 5'd9) begin n_err++; $display("FAIL s0_replace: got v=%0b d=%0h c=%0h want v=1 d=22 c=9", bus0.OValid, bus0.OData, bus0.OCtrl); end
        n_cmp++; if (bus0.Count !== 2'd1) begin n_err++; $display("FAIL s0_count: got %0d want 1", bus0.Count); end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [BW-1:0] h1, h0;
        logic          ev1, ev0;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, CW'($urandom_range(0, 31)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            tick();
            ev1 = (exp_q1.size() != 0);
            ev0 = (exp_q0.size() != 0);
            h1  = ev1 ? exp_q1[0] : '0;
            h0  = ev0 ? exp_q0[0] : '0;
            n_cmp++; if (bus1.OValid !== ev1) begin n_err++; $display("FAIL rnd_ovalid1 @%0d: got %0b want %0b", n, bus1.OValid, ev1); end
            n_cmp++; if (ev1 && bus1.OData !== h1[DW-1:0]) begin n_err++; $display("FAIL rnd_odata1 @%0d: got %0h want %0h", n, bus1.OData, h1[DW-1:0]); end
            n_cmp++; if (bus1.OCtrl !== h1[BW-1:DW]) begin n_err++; $display("FAIL rnd_octrl1 @%0d: got %0h want %0h", n, bus1.OCtrl, h1[BW-1:DW]); end
            n_cmp++; if (bus1.Count !== 2'(exp_q1.size())) begin n_err++; $display("FAIL rnd_count1 @%0d: got %0d want %0d", n, bus1.Count, exp_q1.size()); end
            n_cmp++; if (bus1.IReady !== (exp_q1.size() < 2)) begin n_err++; $display("FAIL rnd_iready1 @%0d: got %0b", n, bus1.IReady); end
            n_cmp++; if (bus0.OValid !== ev0) begin n_err++; $display("FAIL rnd_ovalid0 @%0d: got %0b want %0b", n, bus0.OValid, ev0); end
            n_cmp++; if (ev0 && bus0.OData !== h0[DW-1:0]) begin n_err++; $display("FAIL rnd_odata0 @%0d: got %0h want %0h", n, bus0.OData, h0[DW-1:0]); end
            n_cmp++; if (bus0.OCtrl !== h0[BW-1:DW]) begin n_err++; $display("FAIL rnd_octrl0 @%0d: got %0h want %0h", n, bus0.OCtrl, h0[BW-1:DW]); end
            n_cmp++; if (bus0.Count !== 2'(exp_q0.size())) begin n_err++; $display("FAIL rnd_count0 @%0d: got %0d want %0d", n, bus0.Count, exp_q0.size()); end
            n_cmp++; if (bus0.IReady !== (!ev0 || ordy)) begin n_err++; $display("FAIL rnd_iready0 @%0d: got %0b", n, bus0.IReady); end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h7, 5'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8, 5'd6, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus1.Count !== 2'd2) begin n_err++; $display("FAIL areset_pre: got %0d want 2", bus1.Count); end
        #2;
        rst_n = 1'b0;
        exp_q1.delete();
        exp_q0.delete();
        #1;
        n_cmp++; if (bus1.OValid !== 1'b0 || bus1.Count !== 2'd0) begin n_err++; $display("FAIL areset_now1: got v=%0b n=%0d want v=0 n=0", bus1.OValid, bus1.Count); end
        n_cmp++; if (bus0.OValid !== 1'b0 || bus0.Count !== 2'd0) begin n_err++; $display("FAIL areset_now0: got v=%0b n=%0d want v=0 n=0", bus0.OValid, bus0.Count); end
        n_cmp++; if (bus1.IReady !== 1'b1 || bus1.OData !== 32'h0 || bus1.OCtrl !== 5'd0) begin n_err++; $display("FAIL areset_regs1: got r=%0b d=%0h c=%0h want r=1 d=0 c=0", bus1.IReady, bus1.OData, bus1.OCtrl); end
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus1.OValid !== 1'b0 || bus0.OValid !== 1'b0) begin n_err++; $display("FAIL areset_after: got %0b/%0b want 0/0", bus1.OValid, bus0.OValid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_skid0_stall();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
